// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - request/response handshake bundle for data_mem_resp
interface data_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - single-outstanding word memory with byte-enable stores and fixed read latency
module data_mem_resp #(
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_resp_if.slave   bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT   = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          resp_valid_q;
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic          accept;
  logic          addr_err;
  logic [AW-1:0] idx;

  logic [31:0]   mem [0:DEPTH-1];

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  assign accept   = bus.req_valid && (state == IDLE);
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
  assign idx      = bus.req_addr[AW+1:2];

  // Memory has no reset; a store commits on its acceptance edge and survives a later abort.
  always_ff @(posedge clk) begin
    if (accept && !reset && bus.req_we && !addr_err) begin
      if (bus.req_be[0]) mem[idx][7:0]   <= bus.req_wdata[7:0];
      if (bus.req_be[1]) mem[idx][15:8]  <= bus.req_wdata[15:8];
      if (bus.req_be[2]) mem[idx][23:16] <= bus.req_wdata[23:16];
      if (bus.req_be[3]) mem[idx][31:24] <= bus.req_wdata[31:24];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= WAIT;
            cnt     <= CNT_INIT;
            err_q   <= addr_err;
            // Load data is sampled now so the response reflects memory at acceptance.
            rdata_q <= (addr_err || bus.req_we) ? 32'd0 : mem[idx];
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_q;
            resp_err_q   <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
